// File: rtl/blink_scheduler_if.sv
// Request/grant bundle between the central FSM (master) and the blink
// scheduler (slave); the display drivers read grant/blink_out/led.
interface blink_scheduler_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req;
   logic [4*N_REQ-1:0] req_count;
   logic [N_REQ-1:0]   cancel;
   logic [N_REQ-1:0]   req_ack;
   logic [N_REQ-1:0]   grant;
   logic               blink_out;
   logic [N_REQ-1:0]   led;
   logic [N_REQ-1:0]   done;
   logic               busy;

   modport master (
      output req, req_count, cancel,
      input  req_ack, grant, blink_out, led, done, busy
   );

   modport slave (
      input  req, req_count, cancel,
      output req_ack, grant, blink_out, led, done, busy
   );
endinterface

// File: rtl/blink_scheduler.sv
// Round-robin owner of one shared blink timebase: each requester queues a
// burst of 1..15 ON/OFF periods, and bursts run one at a time.
module blink_scheduler #(
   parameter int N_REQ         = 4,
   parameter int PERIOD_CYCLES = 27000000,
   parameter int ON_CYCLES     = 6750000
) (
   input logic          clk,
   input logic          reset,
   blink_scheduler_if.slave bus
);
   localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
   localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYCLES - 1);
   localparam logic [PW-1:0] OFF_LAST = PW'(PERIOD_CYCLES - ON_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ON,
      OFF
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [3:0]       remaining_q, remaining_d;
   logic [IW-1:0]    last_q, last_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [3:0]       count_q [N_REQ];
   logic [3:0]       count_d [N_REQ];
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic [N_REQ-1:0] led_q, led_d;
   logic             blink_q, blink_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] avail;
   logic [IW-1:0]    sel;
   logic             found;
   int               idx;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      remaining_d = remaining_q;
      last_d      = last_q;
      grant_d     = grant_q;
      count_d     = count_q;
      ack_d       = '0;
      done_d      = '0;
      found       = 1'b0;
      sel         = '0;
      idx         = 0;

      // Cancels take effect before intake and arbitration so a cancelled
      // requester can neither be acked nor granted on the same edge.
      for (int i = 0; i < N_REQ; i++) begin
         if (bus.cancel[i] && (pending_q[i] || grant_q[i])) begin
            done_d[i] = 1'b1;
         end
      end
      pending_d = pending_q & ~bus.cancel;
      avail     = pending_q & ~bus.cancel;

      for (int i = 0; i < N_REQ; i++) begin
         if (bus.req[i] && !bus.cancel[i] && (bus.req_count[4*i +: 4] != 4'd0)
             && !pending_q[i] && !grant_q[i]) begin
            pending_d[i] = 1'b1;
            count_d[i]   = bus.req_count[4*i +: 4];
            ack_d[i]     = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            for (int off = 1; off <= N_REQ; off++) begin
               idx = (int'(last_q) + off) % N_REQ;
               if (!found && avail[idx]) begin
                  found = 1'b1;
                  sel   = IW'(idx);
               end
            end
            if (found) begin
               grant_d        = '0;
               grant_d[sel]   = 1'b1;
               last_d         = sel;
               remaining_d    = count_q[sel];
               pending_d[sel] = 1'b0;
               phase_d        = '0;
               state_d        = ON;
            end
         end
         ON: begin
            if (phase_q == ON_LAST) begin
               phase_d = '0;
               state_d = OFF;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         OFF: begin
            if (phase_q == OFF_LAST) begin
               phase_d = '0;
               if (remaining_q == 4'd1) begin
                  done_d  = done_d | grant_q;
                  grant_d = '0;
                  state_d = IDLE;
               end else begin
                  remaining_d = remaining_q - 4'd1;
                  state_d     = ON;
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (|(bus.cancel & grant_q)) begin
         grant_d = '0;
         phase_d = '0;
         state_d = IDLE;
      end

      blink_d = (state_d == ON);
      busy_d  = (state_d != IDLE);
      led_d   = grant_d & {N_REQ{blink_d}};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         remaining_q <= '0;
         last_q      <= IW'(N_REQ - 1);
         pending_q   <= '0;
         count_q     <= '{default: '0};
         grant_q     <= '0;
         ack_q       <= '0;
         done_q      <= '0;
         led_q       <= '0;
         blink_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         remaining_q <= remaining_d;
         last_q      <= last_d;
         pending_q   <= pending_d;
         count_q     <= count_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         led_q       <= led_d;
         blink_q     <= blink_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ack   = ack_q;
   assign bus.grant     = grant_q;
   assign bus.blink_out = blink_q;
   assign bus.led       = led_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_blink_scheduler.sv
// Bench for blink_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a burst-level model (elapsed cycles per burst).
module tb_blink_scheduler;
   localparam int N  = 4;
   localparam int P  = 8;
   localparam int ON = 2;

   logic clk = 1'b0;
   logic reset;

   blink_scheduler_if #(.N_REQ(N)) bus();

   blink_scheduler #(.N_REQ(N), .PERIOD_CYCLES(P), .ON_CYCLES(ON)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] mPend;
   int           mCnt [N];
   int           mOwner, mLast, mElapsed, mTotal;
   logic [N-1:0] eAck, eDone, eGrant;
   logic         eBlink, eBusy;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock edge of the reference: a burst owns the timer for count*P
   // cycles and blinks high for the first ON cycles of every period.
   task automatic modelStep();
      logic [N-1:0] avail, nPend;
      int sel, idx;
      eAck  = '0;
      eDone = '0;
      if (reset) begin
         mPend    = '0;
         mOwner   = -1;
         mLast    = N - 1;
         mElapsed = 0;
         mTotal   = 0;
      end else begin
         for (int i = 0; i < N; i++)
            if (bus.cancel[i] && (mPend[i] || mOwner == i)) eDone[i] = 1'b1;
         nPend = mPend & ~bus.cancel;
         for (int i = 0; i < N; i++) begin
            if (bus.req[i] && !bus.cancel[i] && bus.req_count[4*i +: 4] != 4'd0
                && !mPend[i] && mOwner != i) begin
               nPend[i] = 1'b1;
               mCnt[i]  = int'(bus.req_count[4*i +: 4]);
               eAck[i]  = 1'b1;
            end
         end
         if (mOwner < 0) begin
            avail = mPend & ~bus.cancel;
            sel   = -1;
            for (int off = 1; off <= N; off++) begin
               idx = (mLast + off) % N;
               if (sel < 0 && avail[idx]) sel = idx;
            end
            if (sel >= 0) begin
               mOwner     = sel;
               mLast      = sel;
               mElapsed   = 0;
               mTotal     = mCnt[sel] * P;
               nPend[sel] = 1'b0;
            end
         end else if (bus.cancel[mOwner]) begin
            mOwner = -1;
         end else begin
            mElapsed++;
            if (mElapsed == mTotal) begin
               eDone[mOwner] = 1'b1;
               mOwner        = -1;
            end
         end
         mPend = nPend;
      end
      eGrant = '0;
      if (mOwner >= 0) eGrant[mOwner] = 1'b1;
      eBlink = (mOwner >= 0) && ((mElapsed % P) < ON);
      eBusy  = (mOwner >= 0);
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic [4*N-1:0] c,
                                input logic [N-1:0] x, input logic rst);
      bus.req       = r;
      bus.req_count = c;
      bus.cancel    = x;
      reset         = rst;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("req_ack", 32'(bus.req_ack), 32'(eAck));
      checkOutput("grant", 32'(bus.grant), 32'(eGrant));
      checkOutput("blink_out", 32'(bus.blink_out), 32'(eBlink));
      checkOutput("led", 32'(bus.led), 32'(eGrant & {N{eBlink}}));
      checkOutput("done", 32'(bus.done), 32'(eDone));
      checkOutput("busy", 32'(bus.busy), 32'(eBusy));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus('0, '0, '0, 1'b0);
   endtask

   function automatic logic [4*N-1:0] cnt(input int i, input int v);
      logic [4*N-1:0] c;
      c          = '0;
      c[4*i +: 4] = 4'(v);
      return c;
   endfunction

   int           len;
   logic [N-1:0] prevGrant;
   logic [N-1:0] order [$];
   logic [N-1:0] r, x;
   logic [4*N-1:0] c;

   initial begin
      bus.req = '0; bus.req_count = '0; bus.cancel = '0; reset = 1'b1;
      mOwner = -1; mLast = N - 1; mPend = '0;
      for (int i = 0; i < N; i++) mCnt[i] = 0;
      @(negedge clk);
      applyStimulus('0, '0, '0, 1'b1);
      applyStimulus('0, '0, '0, 1'b1);
      checkOutput("resetBusy", 32'(bus.busy), 32'd0);

      // single request of 3 blinks on requester 1
      applyStimulus(4'b0010, cnt(1, 3), '0, 1'b0);
      checkOutput("singleAck", 32'(bus.req_ack), 32'h2);
      len = 0;
      for (int k = 0; k < 30; k++) begin
         applyStimulus('0, '0, '0, 1'b0);
         if (bus.grant[1]) len++;
      end
      checkOutput("singleBurstLen", 32'(len), 32'd24);

      // make requester 2 the last granted, then a three-way request
      applyStimulus(4'b0100, cnt(2, 1), '0, 1'b0);
      idle(12);
      applyStimulus(4'b1101, cnt(0, 1) | cnt(2, 1) | cnt(3, 1), '0, 1'b0);
      prevGrant = '0;
      order.delete();
      for (int k = 0; k < 40; k++) begin
         applyStimulus('0, '0, '0, 1'b0);
         if (bus.grant != '0 && prevGrant == '0) order.push_back(bus.grant);
         prevGrant = bus.grant;
      end
      checkOutput("rrCount", 32'(order.size()), 32'd3);
      checkOutput("rrFirst", 32'(order.size() > 0 ? order[0] : '0), 32'h8);
      checkOutput("rrSecond", 32'(order.size() > 1 ? order[1] : '0), 32'h1);
      checkOutput("rrThird", 32'(order.size() > 2 ? order[2] : '0), 32'h4);

      // zero count is rejected
      applyStimulus(4'b1000, cnt(3, 0), '0, 1'b0);
      checkOutput("zeroAck", 32'(bus.req_ack), 32'd0);
      idle(2);
      checkOutput("zeroBusy", 32'(bus.busy), 32'd0);

      // re-request during own burst is ignored
      applyStimulus(4'b0010, cnt(1, 3), '0, 1'b0);
      len = 0;
      for (int k = 0; k < 30; k++) begin
         if (k == 5) applyStimulus(4'b0010, cnt(1, 5), '0, 1'b0);
         else applyStimulus('0, '0, '0, 1'b0);
         if (bus.grant[1]) len++;
      end
      checkOutput("reReqBurstLen", 32'(len), 32'd24);

      // cancel on the 10th blink cycle with requester 3 waiting
      applyStimulus(4'b0010, cnt(1, 3), '0, 1'b0);
      idle(2);
      applyStimulus(4'b1000, cnt(3, 2), '0, 1'b0);
      idle(6);
      applyStimulus('0, '0, 4'b0010, 1'b0);
      checkOutput("cancelGrant", 32'(bus.grant), 32'd0);
      checkOutput("cancelDone", 32'(bus.done), 32'h2);
      idle(1);
      checkOutput("cancelNext", 32'(bus.grant), 32'h8);
      idle(20);

      // same-cycle request and cancel
      applyStimulus(4'b0100, cnt(2, 4), 4'b0100, 1'b0);
      checkOutput("reqCancelAck", 32'(bus.req_ack), 32'd0);
      checkOutput("reqCancelDone", 32'(bus.done), 32'd0);
      idle(3);
      checkOutput("reqCancelBusy", 32'(bus.busy), 32'd0);

      // reset mid-ON with two pending requesters
      applyStimulus(4'b0010, cnt(1, 3), '0, 1'b0);
      applyStimulus(4'b0101, cnt(0, 2) | cnt(2, 2), '0, 1'b0);
      applyStimulus('0, '0, '0, 1'b1);
      checkOutput("midResetGrant", 32'(bus.grant), 32'd0);
      len = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus('0, '0, '0, 1'b0);
         if (bus.grant != '0) len++;
      end
      checkOutput("postResetGrants", 32'(len), 32'd0);

      // random traffic
      for (int k = 0; k < 4000; k++) begin
         r = '0; x = '0; c = '0;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0) r[i] = 1'b1;
            if ($urandom_range(0, 63) == 0) x[i] = 1'b1;
            c[4*i +: 4] = 4'($urandom_range(0, 4));
         end
         applyStimulus(r, c, x, ($urandom_range(0, 999) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
